// File: rtl/write_sched_pkg.sv
// rtl/write_sched_pkg.sv - shared types, burst-length codes and helpers for the write command scheduler
package write_sched_pkg;

   localparam logic [1:0] BL16    = 2'b00;
   localparam logic [1:0] BC8     = 2'b01;
   localparam logic [1:0] BL32    = 2'b10;
   localparam logic [1:0] BL_RSVD = 2'b11;

   // Issue times are stored at this width; the scheduler's TS_W must not exceed it.
   localparam int TS_MAX_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      BURST
   } sched_state_e;

   typedef struct packed {
      logic [TS_MAX_W-1:0] issue;
      logic [4:0]          n;
      logic [1:0]          bl;
   } entry_t;

   // Number of o_wr_en cycles for a burst; the reserved code behaves like BL16.
   function automatic logic [4:0] burst_cycles(input logic [1:0] bl, input logic crc);
      logic [4:0] base;
      case (bl)
         BC8:     base = 5'd4;
         BL32:    base = 5'd16;
         default: base = 5'd8;
      endcase
      return base + {4'b0000, crc};
   endfunction

endpackage

// File: rtl/write_cmd_scheduler_if.sv
// rtl/write_cmd_scheduler_if.sv - command-side and write_manager-side signals of the scheduler
interface write_cmd_scheduler_if;

   logic       i_enable;
   logic       i_wr_cmd;
   logic [1:0] i_burstlength;
   logic [5:0] i_wr_latency;
   logic [2:0] i_precycle;
   logic       i_phy_crc_mode;
   logic       i_DRAM_crc_en;

   logic       o_wr_en;
   logic [1:0] o_burstlength;
   logic       o_cmd_ready;
   logic       o_cmd_reject;
   logic       o_timing_err;
   logic       o_burst_done;
   logic       o_busy;

   modport master (
      output i_enable, i_wr_cmd, i_burstlength, i_wr_latency, i_precycle,
             i_phy_crc_mode, i_DRAM_crc_en,
      input  o_wr_en, o_burstlength, o_cmd_ready, o_cmd_reject, o_timing_err,
             o_burst_done, o_busy
   );

   modport slave (
      input  i_enable, i_wr_cmd, i_burstlength, i_wr_latency, i_precycle,
             i_phy_crc_mode, i_DRAM_crc_en,
      output o_wr_en, o_burstlength, o_cmd_ready, o_cmd_reject, o_timing_err,
             o_burst_done, o_busy
   );

endinterface

// File: rtl/wr_cmd_fifo.sv
// rtl/wr_cmd_fifo.sv - in-order pending-command queue with show-ahead head
module wr_cmd_fifo
   import write_sched_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic   i_clk,
   input  logic   i_rst,
   input  logic   push,
   input  entry_t wdata,
   input  logic   pop,
   output entry_t head,
   output logic   full,
   output logic   empty
);

   localparam int AW = $clog2(DEPTH);

   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Storage array; no reset needed because empty masks stale entries.
   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/write_cmd_scheduler.sv
// rtl/write_cmd_scheduler.sv - schedules write commands so write_manager's window opens at WL - precycle
module write_cmd_scheduler
   import write_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TS_W  = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   write_cmd_scheduler_if.slave  bus
);

   sched_state_e    state_q, state_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [1:0]      bl_q, bl_d;
   logic [TS_W-1:0] now_q;
   logic [TS_W-1:0] now_p1;
   logic [4:0]      gap_q;
   logic [4:0]      n_prev_q;
   logic            reject_q;
   logic            terr_q;

   logic            crc;
   logic [4:0]      n_new;
   logic [1:0]      bl_new;
   logic            clamp;
   logic [5:0]      lead;
   logic [TS_W-1:0] issue_new;
   logic            spacing_ok;
   logic            accept;
   entry_t          new_entry;
   entry_t          fifo_head;
   entry_t          cand;
   logic            fifo_full;
   logic            fifo_empty;
   logic            cand_due;
   logic            can_start;
   logic            start;
   logic            push;
   logic            pop;

   assign crc        = bus.i_phy_crc_mode & bus.i_DRAM_crc_en;
   assign n_new      = burst_cycles(bus.i_burstlength, crc);
   assign bl_new     = (bus.i_burstlength == BL_RSVD) ? BL16 : bus.i_burstlength;
   assign clamp      = (bus.i_wr_latency <= {3'b000, bus.i_precycle});
   assign lead       = clamp ? 6'd1 : (bus.i_wr_latency - {3'b000, bus.i_precycle});
   assign issue_new  = now_q + TS_W'(lead);
   assign now_p1     = now_q + TS_W'(1);

   // Spacing is measured from the last accepted command; an idle scheduler always accepts.
   assign spacing_ok = (state_q == IDLE) || (gap_q >= n_prev_q);
   assign accept     = bus.i_wr_cmd & bus.i_enable & ~fifo_full & spacing_ok;

   // Burst-start decision looks one cycle ahead because o_wr_en is registered. With an empty
   // queue the incoming command itself is the candidate, which lets a lead of 1 start at T+1.
   always_comb begin
      new_entry.issue = TS_MAX_W'(issue_new);
      new_entry.n     = n_new;
      new_entry.bl    = bl_new;
      cand            = fifo_empty ? new_entry : fifo_head;
      cand_due        = (~fifo_empty | accept) && (cand.issue == TS_MAX_W'(now_p1));
      can_start       = (state_q != BURST) || (cnt_q == 5'd1);
      start           = can_start & cand_due;
      pop             = start & ~fifo_empty;
      push            = accept & ~(start & fifo_empty);
   end

   wr_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .push  (push),
      .wdata (new_entry),
      .pop   (pop),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next state: start a burst when due, otherwise count down or fall back to WAIT/IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bl_d    = bl_q;
      if (start) begin
         state_d = BURST;
         cnt_d   = cand.n;
         bl_d    = cand.bl;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_d = WAIT;
               end
            end
            WAIT: begin
               state_d = WAIT;
            end
            BURST: begin
               if (cnt_q == 5'd1) begin
                  state_d = (~fifo_empty | push) ? WAIT : IDLE;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State register with burst counter and active burst length.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bl_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bl_q    <= bl_d;
      end
   end

   // Free-running timestamp, spacing tracker and registered status pulses.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         now_q    <= '0;
         gap_q    <= '1;
         n_prev_q <= '0;
         reject_q <= 1'b0;
         terr_q   <= 1'b0;
      end else begin
         now_q <= now_p1;
         if (accept) begin
            gap_q    <= 5'd1;
            n_prev_q <= n_new;
         end else if (gap_q != 5'd31) begin
            gap_q <= gap_q + 5'd1;
         end
         reject_q <= bus.i_wr_cmd & bus.i_enable & ~accept;
         terr_q   <= accept & clamp;
      end
   end

   assign bus.o_wr_en       = (state_q == BURST);
   assign bus.o_burstlength = (state_q == BURST) ? bl_q : 2'b00;
   assign bus.o_burst_done  = (state_q == BURST) && (cnt_q == 5'd1);
   assign bus.o_busy        = (state_q != IDLE);
   assign bus.o_cmd_ready   = ~fifo_full;
   assign bus.o_cmd_reject  = reject_q;
   assign bus.o_timing_err  = terr_q;

endmodule

// File: tb/tb_write_cmd_scheduler.sv
// tb/tb_write_cmd_scheduler.sv - directed self-checking bench with a burst-window scoreboard
module tb_write_cmd_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;

   write_cmd_scheduler_if bus ();

   write_cmd_scheduler #(
      .DEPTH (4),
      .TS_W  (8)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         start;
      int         len;
      logic [1:0] bl;
   } burst_t;

   burst_t exp_bursts[$];
   int     exp_rej[$];
   int     exp_terr[$];
   int     cyc    = 0;
   int     total  = 0;
   int     passed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total = total + 1;
      assert (obs === expv) passed = passed + 1;
      else $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
   endtask

   // Advance one cycle and compare every per-cycle output against the scoreboard.
   task automatic step();
      logic       exp_wr;
      logic       exp_done;
      logic [1:0] exp_bl;
      logic       exp_rj;
      logic       exp_te;
      @(posedge clk);
      #1;
      cyc      = cyc + 1;
      exp_wr   = 1'b0;
      exp_done = 1'b0;
      exp_bl   = 2'b00;
      if (exp_bursts.size() > 0) begin
         if (cyc >= exp_bursts[0].start) begin
            exp_wr   = 1'b1;
            exp_bl   = exp_bursts[0].bl;
            exp_done = (cyc == exp_bursts[0].start + exp_bursts[0].len - 1);
         end
      end
      check("wr_en", 32'(bus.o_wr_en), 32'(exp_wr));
      check("burstlength", 32'(bus.o_burstlength), 32'(exp_bl));
      check("burst_done", 32'(bus.o_burst_done), 32'(exp_done));
      if (exp_done) begin
         void'(exp_bursts.pop_front());
      end
      exp_rj = 1'b0;
      if (exp_rej.size() > 0) begin
         exp_rj = (exp_rej[0] == cyc);
      end
      check("cmd_reject", 32'(bus.o_cmd_reject), 32'(exp_rj));
      if (exp_rj) begin
         void'(exp_rej.pop_front());
      end
      exp_te = 1'b0;
      if (exp_terr.size() > 0) begin
         exp_te = (exp_terr[0] == cyc);
      end
      check("timing_err", 32'(bus.o_timing_err), 32'(exp_te));
      if (exp_te) begin
         void'(exp_terr.pop_front());
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
      end
   endtask

   // Drive a one-cycle command strobe and record what the spec says must follow.
   task automatic send(input int wl, input int pre, input logic [1:0] bl,
                       input logic cm, input logic cd, input logic en, input logic exp_ok);
      int         t;
      int         l;
      int         n;
      logic [1:0] blv;
      t = cyc;
      bus.i_wr_cmd        = 1'b1;
      bus.i_enable        = en;
      bus.i_wr_latency    = 6'(wl);
      bus.i_precycle      = 3'(pre);
      bus.i_burstlength   = bl;
      bus.i_phy_crc_mode  = cm;
      bus.i_DRAM_crc_en   = cd;
      if (exp_ok) begin
         l   = (wl <= pre) ? 1 : wl - pre;
         n   = (bl == 2'b01) ? 4 : (bl == 2'b10) ? 16 : 8;
         n   = n + ((cm && cd) ? 1 : 0);
         blv = (bl == 2'b11) ? 2'b00 : bl;
         exp_bursts.push_back('{t + l, n, blv});
         if (wl <= pre) begin
            exp_terr.push_back(t + 1);
         end
      end else if (en) begin
         exp_rej.push_back(t + 1);
      end
      step();
      bus.i_wr_cmd = 1'b0;
   endtask

   initial begin
      bus.i_wr_cmd       = 1'b0;
      bus.i_enable       = 1'b1;
      bus.i_burstlength  = 2'b00;
      bus.i_wr_latency   = 6'd10;
      bus.i_precycle     = 3'd4;
      bus.i_phy_crc_mode = 1'b0;
      bus.i_DRAM_crc_en  = 1'b0;

      // Reset state
      idle(3);
      check("reset_busy", 32'(bus.o_busy), 32'd0);
      check("reset_ready", 32'(bus.o_cmd_ready), 32'd1);
      rst = 1'b0;
      idle(2);

      // Single BL16, WL=10, precycle=4: window T+6..T+13
      send(10, 4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      check("busy_wait", 32'(bus.o_busy), 32'd1);
      idle(16);
      check("busy_idle", 32'(bus.o_busy), 32'd0);

      // CRC both set adds a cycle; one flag alone does not
      send(10, 4, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
      idle(16);
      send(10, 4, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
      idle(16);

      // BC8, BL32 and the reserved code
      send(10, 4, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(24);
      send(10, 4, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(24);
      send(10, 4, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(24);

      // Back-to-back BL16 at T and T+8: seamless window
      send(10, 4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(7);
      send(10, 4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(24);

      // Spacing violation at T+5
      send(10, 4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(4);
      send(10, 4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(20);

      // WL=60: four queue up, fifth hits a full queue
      for (int i = 0; i < 4; i++) begin
         check("ready_not_full", 32'(bus.o_cmd_ready), 32'd1);
         send(60, 4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
         idle(7);
      end
      check("ready_full", 32'(bus.o_cmd_ready), 32'd0);
      send(60, 4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(60);
      check("ready_drained", 32'(bus.o_cmd_ready), 32'd1);

      // Lead clamp: WL below and equal to precycle
      send(3, 4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(12);
      send(4, 4, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(8);

      // Enable dropped: in-flight burst drains, new command ignored silently
      send(10, 4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(2);
      send(10, 4, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(16);
      check("busy_after_disable", 32'(bus.o_busy), 32'd0);
      bus.i_enable = 1'b1;

      // Reset mid-burst with a second command queued
      send(10, 4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(7);
      send(10, 4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(1);
      rst = 1'b1;
      #1;
      check("rst_wr_en", 32'(bus.o_wr_en), 32'd0);
      check("rst_burstlength", 32'(bus.o_burstlength), 32'd0);
      check("rst_burst_done", 32'(bus.o_burst_done), 32'd0);
      check("rst_busy", 32'(bus.o_busy), 32'd0);
      check("rst_ready", 32'(bus.o_cmd_ready), 32'd1);
      exp_bursts.delete();
      idle(2);
      rst = 1'b0;
      idle(30);
      send(10, 4, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(24);

      check("scoreboard_empty", 32'(exp_bursts.size() + exp_rej.size() + exp_terr.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
